// File: rtl/wt_dcache_ship_pred_if.sv
// Bus between the write-through dcache and the SHiP insertion predictor:
// prediction request/response, training events and flush control.
interface wt_dcache_ship_pred_if #(
  parameter int NUM_WORDS = 256,
  parameter int SET_ASSOC = 4,
  parameter int PC_WIDTH  = 64
);
  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam int WAY_W = $clog2(SET_ASSOC);

  logic                flush_i;
  logic                busy_o;
  logic                pred_req_i;
  logic [PC_WIDTH-1:0] pred_pc_i;
  logic                pred_valid_o;
  logic [1:0]          pred_result_o;
  logic                fill_i;
  logic [IDX_W-1:0]    fill_idx_i;
  logic [WAY_W-1:0]    fill_way_i;
  logic                hit_i;
  logic [IDX_W-1:0]    hit_idx_i;
  logic [WAY_W-1:0]    hit_way_i;
  logic                evict_i;
  logic [IDX_W-1:0]    evict_idx_i;
  logic [WAY_W-1:0]    evict_way_i;

  modport master (
    output flush_i, pred_req_i, pred_pc_i,
    output fill_i, fill_idx_i, fill_way_i,
    output hit_i, hit_idx_i, hit_way_i,
    output evict_i, evict_idx_i, evict_way_i,
    input  busy_o, pred_valid_o, pred_result_o
  );

  modport slave (
    input  flush_i, pred_req_i, pred_pc_i,
    input  fill_i, fill_idx_i, fill_way_i,
    input  hit_i, hit_idx_i, hit_way_i,
    input  evict_i, evict_idx_i, evict_way_i,
    output busy_o, pred_valid_o, pred_result_o
  );
endinterface

// File: rtl/wt_dcache_ship_pred.sv
// SHiP insertion predictor: PC signatures index a table of saturating counters
// trained by fill/hit/evict events; predicts the RRPV for newly inserted lines.
module wt_dcache_ship_pred #(
  parameter int NUM_WORDS = 256,
  parameter int SET_ASSOC = 4,
  parameter int SIG_WIDTH = 8,
  parameter int CTR_WIDTH = 2,
  parameter int PC_WIDTH  = 64
) (
  input logic clk_i,
  input logic rst_i,
  wt_dcache_ship_pred_if.slave bus
);
  localparam int SHCT_N = 2 ** SIG_WIDTH;
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'(1);

  typedef enum logic {IDLE, WALK} state_t;

  state_t state, state_next;

  logic [CTR_WIDTH-1:0] shct [SHCT_N];
  logic [SIG_WIDTH-1:0] meta_sig     [NUM_WORDS][SET_ASSOC];
  logic                 meta_outcome [NUM_WORDS][SET_ASSOC];
  logic                 meta_valid   [NUM_WORDS][SET_ASSOC];

  logic [SIG_WIDTH-1:0] wptr, last_sig, req_sig, hit_sig, evict_sig;
  logic                 walking, start_walk, same_line, hit_inc, evict_dec, cancel;
  logic                 pred_valid;
  logic [1:0]           pred_result;
  logic                 unused_pc;

  assign req_sig   = bus.pred_pc_i[SIG_WIDTH+1:2] ^ bus.pred_pc_i[2*SIG_WIDTH+1:SIG_WIDTH+2];
  assign unused_pc = ^{bus.pred_pc_i[PC_WIDTH-1:2*SIG_WIDTH+2], bus.pred_pc_i[1:0]};

  // Training decisions; a hit on a line evicted in the same cycle never counts as reuse.
  always_comb begin
    hit_sig   = meta_sig[bus.hit_idx_i][bus.hit_way_i];
    evict_sig = meta_sig[bus.evict_idx_i][bus.evict_way_i];
    same_line = (bus.hit_idx_i == bus.evict_idx_i) && (bus.hit_way_i == bus.evict_way_i);
    hit_inc   = bus.hit_i && meta_valid[bus.hit_idx_i][bus.hit_way_i] && !walking &&
                !(bus.evict_i && same_line);
    evict_dec = bus.evict_i && meta_valid[bus.evict_idx_i][bus.evict_way_i] &&
                !meta_outcome[bus.evict_idx_i][bus.evict_way_i] && !walking;
    cancel    = hit_inc && evict_dec && (hit_sig == evict_sig);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.flush_i) state_next = WALK;
      WALK:    if (wptr == '1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    walking    = (state == WALK);
    start_walk = (state == IDLE) && bus.flush_i;
    bus.busy_o = walking;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)           wptr <= '0;
    else if (start_walk) wptr <= '0;
    else if (walking)    wptr <= wptr + SIG_WIDTH'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SHCT_N; i++) shct[i] <= CTR_INIT;
    end else if (walking) begin
      shct[wptr] <= CTR_INIT;
    end else begin
      if (hit_inc && !cancel)
        shct[hit_sig] <= (shct[hit_sig] == CTR_MAX) ? CTR_MAX : shct[hit_sig] + CTR_WIDTH'(1);
      if (evict_dec && !cancel)
        shct[evict_sig] <= (shct[evict_sig] == '0) ? '0 : shct[evict_sig] - CTR_WIDTH'(1);
    end
  end

  // Write order gives the fill the final say when it targets the evicted line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || start_walk) begin
      for (int i = 0; i < NUM_WORDS; i++)
        for (int j = 0; j < SET_ASSOC; j++) begin
          meta_valid[i][j]   <= 1'b0;
          meta_outcome[i][j] <= 1'b0;
        end
    end else if (!walking) begin
      if (hit_inc) meta_outcome[bus.hit_idx_i][bus.hit_way_i] <= 1'b1;
      if (bus.evict_i) meta_valid[bus.evict_idx_i][bus.evict_way_i] <= 1'b0;
      if (bus.fill_i) begin
        meta_valid[bus.fill_idx_i][bus.fill_way_i]   <= 1'b1;
        meta_outcome[bus.fill_idx_i][bus.fill_way_i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (bus.fill_i && !walking) meta_sig[bus.fill_idx_i][bus.fill_way_i] <= last_sig;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pred_valid  <= 1'b0;
      pred_result <= 2'd2;
      last_sig    <= '0;
    end else begin
      pred_valid <= bus.pred_req_i;
      if (bus.pred_req_i) begin
        last_sig    <= req_sig;
        pred_result <= (!walking && shct[req_sig] == '0) ? 2'd3 : 2'd2;
      end
    end
  end

  assign bus.pred_valid_o  = pred_valid;
  assign bus.pred_result_o = pred_result;
endmodule

// File: tb/tb_wt_dcache_ship_pred.sv
// Directed bench for the SHiP predictor; counter state is observed through
// predictions (a counter of 0 predicts 3, anything else predicts 2).
module tb_wt_dcache_ship_pred;
  logic clk = 1'b0;
  logic rst;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   n;

  localparam logic [63:0] PC_A   = 64'h1000;
  localparam logic [63:0] PC_B   = 64'h0020;
  localparam logic [63:0] PC_X   = 64'h1010;
  localparam logic [63:0] PC_FAR = 64'h0320;

  wt_dcache_ship_pred_if bus ();

  wt_dcache_ship_pred dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic f, input logic [7:0] fi, input logic [1:0] fw,
                                input logic h, input logic [7:0] hi, input logic [1:0] hw,
                                input logic e, input logic [7:0] ei, input logic [1:0] ew);
    bus.fill_i  = f; bus.fill_idx_i  = fi; bus.fill_way_i  = fw;
    bus.hit_i   = h; bus.hit_idx_i   = hi; bus.hit_way_i   = hw;
    bus.evict_i = e; bus.evict_idx_i = ei; bus.evict_way_i = ew;
    tick();
    bus.fill_i = 1'b0; bus.hit_i = 1'b0; bus.evict_i = 1'b0;
  endtask

  task automatic fill(input logic [7:0] idx, input logic [1:0] way);
    apply_stimulus(1'b1, idx, way, 1'b0, 8'd0, 2'd0, 1'b0, 8'd0, 2'd0);
  endtask

  task automatic hit(input logic [7:0] idx, input logic [1:0] way);
    apply_stimulus(1'b0, 8'd0, 2'd0, 1'b1, idx, way, 1'b0, 8'd0, 2'd0);
  endtask

  task automatic evict(input logic [7:0] idx, input logic [1:0] way);
    apply_stimulus(1'b0, 8'd0, 2'd0, 1'b0, 8'd0, 2'd0, 1'b1, idx, way);
  endtask

  // Unreused line with the last predicted signature: decrements that counter.
  task automatic drain();
    fill(8'd20, 2'd3);
    evict(8'd20, 2'd3);
  endtask

  task automatic pred(input logic [63:0] pc, input logic [1:0] exp, input string tag);
    bus.pred_req_i = 1'b1;
    bus.pred_pc_i  = pc;
    tick();
    bus.pred_req_i = 1'b0;
    check_output({tag, "_valid"}, 32'(bus.pred_valid_o), 32'd1);
    check_output({tag, "_result"}, 32'(bus.pred_result_o), 32'(exp));
    tick();
    check_output({tag, "_drop"}, 32'(bus.pred_valid_o), 32'd0);
    check_output({tag, "_hold"}, 32'(bus.pred_result_o), 32'(exp));
  endtask

  initial begin
    rst = 1'b1;
    bus.flush_i = 1'b0; bus.pred_req_i = 1'b0; bus.pred_pc_i = '0;
    bus.fill_i = 1'b0; bus.fill_idx_i = '0; bus.fill_way_i = '0;
    bus.hit_i = 1'b0; bus.hit_idx_i = '0; bus.hit_way_i = '0;
    bus.evict_i = 1'b0; bus.evict_idx_i = '0; bus.evict_way_i = '0;
    #2;
    check_output("rst_valid", 32'(bus.pred_valid_o), 32'd0);
    check_output("rst_result", 32'(bus.pred_result_o), 32'd2);
    check_output("rst_busy", 32'(bus.busy_o), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Signature 4: counter starts at 1, an unreused line takes it to 0.
    pred(PC_A, 2'd2, "first_pred");
    fill(8'd5, 2'd2);
    evict(8'd5, 2'd2);
    pred(PC_A, 2'd3, "dead_pred");
    // 0x1010 folds to signature 0, whose counter is untouched.
    pred(PC_X, 2'd2, "xor_fold");

    // Five hits saturate at 3; reused eviction leaves it there.
    pred(PC_A, 2'd3, "sat_setup");
    fill(8'd5, 2'd2);
    for (int i = 0; i < 5; i++) hit(8'd5, 2'd2);
    evict(8'd5, 2'd2);
    pred(PC_A, 2'd2, "sat_pred");
    drain();
    drain();
    pred(PC_A, 2'd2, "sat_minus2");
    drain();
    pred(PC_A, 2'd3, "sat_minus3");

    // Hit and evict of the same line: eviction wins, line becomes invalid.
    fill(8'd10, 2'd0);
    hit(8'd10, 2'd0);
    apply_stimulus(1'b0, 8'd0, 2'd0, 1'b1, 8'd10, 2'd0, 1'b1, 8'd10, 2'd0);
    hit(8'd10, 2'd0);
    pred(PC_A, 2'd2, "same_line");
    drain();
    pred(PC_A, 2'd3, "same_line_drain");

    // Increment and decrement of the same counter cancel.
    fill(8'd5, 2'd1);
    hit(8'd5, 2'd1);
    fill(8'd6, 2'd0);
    apply_stimulus(1'b0, 8'd0, 2'd0, 1'b1, 8'd5, 2'd1, 1'b1, 8'd6, 2'd0);
    pred(PC_A, 2'd2, "same_sig");
    drain();
    pred(PC_A, 2'd3, "same_sig_drain");

    // Different counters: A (0 -> 1) and B (1 -> 0) both move.
    pred(PC_A, 2'd3, "diff_setup_a");
    fill(8'd8, 2'd0);
    pred(PC_B, 2'd2, "diff_setup_b");
    fill(8'd9, 2'd0);
    apply_stimulus(1'b0, 8'd0, 2'd0, 1'b1, 8'd8, 2'd0, 1'b1, 8'd9, 2'd0);
    pred(PC_A, 2'd2, "diff_a");
    pred(PC_B, 2'd3, "diff_b");

    // Flush walk with counters 4 and 200 at zero.
    pred(PC_A, 2'd2, "flush_setup_a");
    drain();
    pred(PC_A, 2'd3, "flush_setup_a0");
    pred(PC_FAR, 2'd2, "flush_setup_far");
    drain();
    pred(PC_FAR, 2'd3, "flush_setup_far0");
    fill(8'd11, 2'd0);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    check_output("flush_busy_start", 32'(bus.busy_o), 32'd1);
    n = 0;
    while (bus.busy_o === 1'b1 && n < 400) begin
      n++;
      if (n == 50) bus.flush_i = 1'b1;
      if (n == 51) bus.flush_i = 1'b0;
      if (n == 100) begin bus.pred_req_i = 1'b1; bus.pred_pc_i = PC_FAR; end
      if (n == 101) begin
        bus.pred_req_i = 1'b0;
        check_output("walk_pred_valid", 32'(bus.pred_valid_o), 32'd1);
        check_output("walk_pred_result", 32'(bus.pred_result_o), 32'd2);
      end
      if (n == 150) begin bus.hit_i = 1'b1; bus.hit_idx_i = 8'd11; bus.hit_way_i = 2'd0; end
      if (n == 151) bus.hit_i = 1'b0;
      tick();
    end
    check_output("walk_cycles", 32'(n), 32'd256);
    pred(PC_A, 2'd2, "post_walk_a");
    pred(PC_B, 2'd2, "post_walk_b");
    pred(PC_FAR, 2'd2, "post_walk_far");
    drain();
    pred(PC_FAR, 2'd3, "post_walk_far_drain");

    // Reset in the middle of a walk, before entry 200 is rewritten.
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    n = 0;
    while (bus.busy_o === 1'b1 && n < 100) begin
      n++;
      if (n == 99) begin bus.pred_req_i = 1'b1; bus.pred_pc_i = PC_A; end
      if (n < 100) tick();
    end
    bus.pred_req_i = 1'b0;
    check_output("midwalk_cycle", 32'(n), 32'd100);
    check_output("midwalk_valid", 32'(bus.pred_valid_o), 32'd1);
    rst = 1'b1;
    #1;
    check_output("midwalk_rst_busy", 32'(bus.busy_o), 32'd0);
    check_output("midwalk_rst_valid", 32'(bus.pred_valid_o), 32'd0);
    check_output("midwalk_rst_result", 32'(bus.pred_result_o), 32'd2);
    tick();
    rst = 1'b0;
    tick();
    check_output("after_rst_busy", 32'(bus.busy_o), 32'd0);
    pred(PC_FAR, 2'd2, "after_rst_far");
    pred(PC_A, 2'd2, "after_rst_a");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
